// File: rtl/fft_frame_sched.sv
// Frame scheduler between the ADC sample strobe and the streaming FFT core.
// Optional watchdog on the drain side is built in when FFT_SCHED_WATCHDOG_EN is defined.
module fft_frame_sched #(
  parameter int FFT_LEN = 1024,
  parameter int IDX_W   = 10,
  parameter int GAP_W   = 8,
  parameter int MAX_OUT = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode_cont,
  input  logic [GAP_W-1:0] gap_cycles,
  input  logic             sample_valid,
  input  logic             sink_ready,
  output logic             sink_valid,
  output logic             sink_sop,
  output logic             sink_eop,
  input  logic             source_valid,
  input  logic             source_sop,
  input  logic             source_eop,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_cnt,
  output logic             err_overrun,
  output logic             err_timeout
);

  localparam int OUT_W = 3;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FFT_LEN - 1);
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GAP,
    ST_WAIT_OUT,
    ST_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               mode_q, mode_d;
  logic               stop_pend_q, stop_pend_d;
  logic               sink_valid_q, sink_valid_d;
  logic               sink_sop_q, sink_sop_d;
  logic               sink_eop_q, sink_eop_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               err_overrun_q, err_overrun_d;
  logic               err_timeout_q, err_timeout_d;

  logic accept;
  logic issue;
  logic drain;
  logic stop_seen;

`ifdef FFT_SCHED_WATCHDOG_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;
`else
  logic unused_source_sop;
  assign unused_source_sop = source_sop;
`endif

  assign accept    = (state_q == ST_LOAD) && sample_valid && sink_ready;
  assign issue     = accept && (idx_q == LAST_IDX);
  assign drain     = source_valid && source_eop;
  assign stop_seen = stop_pend_q || stop;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    out_d         = out_q;
    gap_cnt_d     = gap_cnt_q;
    gap_d         = gap_q;
    mode_d        = mode_q;
    stop_pend_d   = stop_pend_q;
    sink_valid_d  = 1'b0;
    sink_sop_d    = 1'b0;
    sink_eop_d    = 1'b0;
    frame_done_d  = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    err_overrun_d = err_overrun_q;
    err_timeout_d = err_timeout_q;

    // Issue and drain in the same clock cancel; a stray drain never underflows.
    if (issue && !drain) begin
      out_d = out_q + 1'b1;
    end else if (drain && !issue && (out_q != '0)) begin
      out_d = out_q - 1'b1;
    end

    if (drain) begin
      frame_done_d = 1'b1;
      frame_cnt_d  = frame_cnt_q + 16'd1;
    end

    if ((state_q != ST_IDLE) && stop) begin
      stop_pend_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        idx_d       = '0;
        stop_pend_d = 1'b0;
        if (start) begin
          mode_d        = mode_cont;
          gap_d         = gap_cycles;
          err_overrun_d = 1'b0;
          err_timeout_d = 1'b0;
          frame_cnt_d   = '0;
          state_d       = (out_q < MAX_OUT_C) ? ST_LOAD : ST_WAIT_OUT;
        end
      end

      ST_LOAD: begin
        if (sample_valid && !sink_ready) begin
          err_overrun_d = 1'b1;
        end else if (accept) begin
          sink_valid_d = 1'b1;
          sink_sop_d   = (idx_q == '0);
          sink_eop_d   = (idx_q == LAST_IDX);
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (!mode_q || stop_seen) begin
              state_d = ST_DRAIN;
            end else if (gap_q != '0) begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_q;
            end else if ((out_q + 1'b1) < MAX_OUT_C) begin
              state_d = ST_LOAD;
            end else begin
              state_d = ST_WAIT_OUT;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (stop_seen) begin
          state_d = ST_DRAIN;
        end else if (gap_cnt_q <= GAP_W'(1)) begin
          gap_cnt_d = '0;
          state_d   = (out_q < MAX_OUT_C) ? ST_LOAD : ST_WAIT_OUT;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end

      ST_WAIT_OUT: begin
        if (stop_seen) begin
          state_d = ST_DRAIN;
        end else if (out_q < MAX_OUT_C) begin
          state_d = ST_LOAD;
        end
      end

      ST_DRAIN: begin
        if (out_q == '0) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

`ifdef FFT_SCHED_WATCHDOG_EN
    // A silent source side with frames in flight gives up and returns to IDLE.
    wd_cnt_d = wd_cnt_q;
    if ((out_q == '0) || (source_valid && (source_sop || source_eop))) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != 16'hFFFF) begin
      wd_cnt_d = wd_cnt_q + 16'd1;
    end
    if ((out_q != '0) && (wd_cnt_q == 16'hFFFF)) begin
      err_timeout_d = 1'b1;
      out_d         = '0;
      stop_pend_d   = 1'b0;
      idx_d         = '0;
      wd_cnt_d      = '0;
      state_d       = ST_IDLE;
    end
`else
    err_timeout_d = 1'b0;
`endif

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      out_q         <= '0;
      gap_cnt_q     <= '0;
      gap_q         <= '0;
      mode_q        <= 1'b0;
      stop_pend_q   <= 1'b0;
      sink_valid_q  <= 1'b0;
      sink_sop_q    <= 1'b0;
      sink_eop_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
`ifdef FFT_SCHED_WATCHDOG_EN
      wd_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      out_q         <= out_d;
      gap_cnt_q     <= gap_cnt_d;
      gap_q         <= gap_d;
      mode_q        <= mode_d;
      stop_pend_q   <= stop_pend_d;
      sink_valid_q  <= sink_valid_d;
      sink_sop_q    <= sink_sop_d;
      sink_eop_q    <= sink_eop_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_cnt_q   <= frame_cnt_d;
      err_overrun_q <= err_overrun_d;
      err_timeout_q <= err_timeout_d;
`ifdef FFT_SCHED_WATCHDOG_EN
      wd_cnt_q      <= wd_cnt_d;
`endif
    end
  end

  assign sink_valid  = sink_valid_q;
  assign sink_sop    = sink_sop_q;
  assign sink_eop    = sink_eop_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_overrun = err_overrun_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Scoreboard bench for fft_frame_sched with 16-point frames and MAX_OUT=2.
// Expected sink beats are queued as strobes are driven and checked as they appear.
module tb_fft_frame_sched;

  localparam int LEN = 16;
  localparam int IW  = 4;
  localparam int GW  = 8;
  localparam int MO  = 2;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          mode_cont = 1'b0;
  logic [GW-1:0] gap_cycles = '0;
  logic          sample_valid = 1'b0;
  logic          sink_ready = 1'b1;
  logic          source_valid = 1'b0;
  logic          source_sop = 1'b0;
  logic          source_eop = 1'b0;
  logic          sink_valid;
  logic          sink_sop;
  logic          sink_eop;
  logic          busy;
  logic          frame_done;
  logic [15:0]   frame_cnt;
  logic          err_overrun;
  logic          err_timeout;

  typedef struct {
    logic sop;
    logic eop;
    int   due;
  } beat_t;

  beat_t sbQueue[$];
  beat_t expBeat;
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    fdSeen = 0;
  int    fdBase = 0;
  int    mIdx = 0;
  int    wdWait = 0;

  fft_frame_sched #(
    .FFT_LEN(LEN),
    .IDX_W  (IW),
    .GAP_W  (GW),
    .MAX_OUT(MO)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .start       (start),
    .stop        (stop),
    .mode_cont   (mode_cont),
    .gap_cycles  (gap_cycles),
    .sample_valid(sample_valid),
    .sink_ready  (sink_ready),
    .sink_valid  (sink_valid),
    .sink_sop    (sink_sop),
    .sink_eop    (sink_eop),
    .source_valid(source_valid),
    .source_sop  (source_sop),
    .source_eop  (source_eop),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .err_overrun (err_overrun),
    .err_timeout (err_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc = cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Every sink beat must match the oldest queued expectation, including its cycle.
  always @(negedge sys_clk) begin
    if (frame_done) fdSeen++;
    if (sink_valid) begin
      if (sbQueue.size() == 0) begin
        checkOutput("spurious_beat", 32'(sink_valid), 32'd0);
      end else begin
        expBeat = sbQueue.pop_front();
        checkOutput("beat_sop", 32'(sink_sop), 32'(expBeat.sop));
        checkOutput("beat_eop", 32'(sink_eop), 32'(expBeat.eop));
        checkOutput("beat_latency", cyc, expBeat.due);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic rdy, input bit accept, input bit drainNow);
    sample_valid = 1'b1;
    sink_ready   = rdy;
    source_valid = drainNow;
    source_eop   = drainNow;
    if (accept) begin
      sbQueue.push_back('{sop: (mIdx == 0), eop: (mIdx == LEN - 1), due: cyc + 1});
      mIdx = (mIdx + 1) % LEN;
    end
    step(1);
    sample_valid = 1'b0;
    sink_ready   = 1'b1;
    source_valid = 1'b0;
    source_eop   = 1'b0;
    step(3);
  endtask

  task automatic sendSamples(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b0);
  endtask

  task automatic startCapture(input logic mode, input logic [GW-1:0] gap);
    mode_cont  = mode;
    gap_cycles = gap;
    start      = 1'b1;
    step(1);
    start      = 1'b0;
    mode_cont  = ~mode;
    gap_cycles = 8'd99;
    mIdx       = 0;
  endtask

  task automatic drainOne();
    source_valid = 1'b1;
    source_eop   = 1'b1;
    step(1);
    source_valid = 1'b0;
    source_eop   = 1'b0;
  endtask

  task automatic pulseStop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  initial begin
    step(2);
    checkOutput("rst_sink_valid", 32'(sink_valid), 0);
    checkOutput("rst_sink_sop", 32'(sink_sop), 0);
    checkOutput("rst_sink_eop", 32'(sink_eop), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_frame_done", 32'(frame_done), 0);
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 0);
    checkOutput("rst_err_overrun", 32'(err_overrun), 0);
    checkOutput("rst_err_timeout", 32'(err_timeout), 0);
    sys_rst_n = 1'b1;
    step(1);

    // Single frame, then one drained output frame.
    startCapture(1'b0, 8'd0);
    checkOutput("t1_busy_start", 32'(busy), 1);
    sendSamples(LEN);
    checkOutput("t1_sb_empty", sbQueue.size(), 0);
    checkOutput("t1_busy_drain", 32'(busy), 1);
    fdBase = fdSeen;
    drainOne();
    checkOutput("t1_frame_done", 32'(frame_done), 1);
    checkOutput("t1_frame_cnt", 32'(frame_cnt), 1);
    step(1);
    checkOutput("t1_frame_done_fall", 32'(frame_done), 0);
    checkOutput("t1_busy_idle", 32'(busy), 0);
    checkOutput("t1_fd_pulses", fdSeen - fdBase, 1);

    // Overrun: strobes 3 and 4 arrive with sink_ready low.
    startCapture(1'b0, 8'd0);
    checkOutput("t3_cnt_cleared", 32'(frame_cnt), 0);
    for (int s = 0; s < LEN + 2; s++) begin
      applyStimulus((s != 3 && s != 4), (s != 3 && s != 4), 1'b0);
    end
    checkOutput("t3_overrun_set", 32'(err_overrun), 1);
    checkOutput("t3_sb_empty", sbQueue.size(), 0);
    drainOne();
    step(1);
    checkOutput("t3_busy_idle", 32'(busy), 0);
    startCapture(1'b0, 8'd0);
    checkOutput("t3_overrun_cleared", 32'(err_overrun), 0);
    sendSamples(5);
    sys_rst_n = 1'b0;
    step(1);
    sys_rst_n = 1'b1;
    mIdx = 0;
    checkOutput("t3_rst_busy", 32'(busy), 0);
    checkOutput("t3_rst_sb_empty", sbQueue.size(), 0);
    step(4);

    // Continuous with gap, no drain: parks after MAX_OUT frames.
    startCapture(1'b1, 8'd5);
    sendSamples(LEN);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t2_gap_no_overrun", 32'(err_overrun), 0);
    sendSamples(LEN);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t2_parked_busy", 32'(busy), 1);
    checkOutput("t2_sb_empty", sbQueue.size(), 0);
    checkOutput("t2_cnt_zero", 32'(frame_cnt), 0);
    drainOne();
    step(1);
    checkOutput("t2_cnt_one", 32'(frame_cnt), 1);

    // Third frame starts with sop; stop at idx 7 lets it finish.
    sendSamples(7);
    pulseStop();
    sendSamples(LEN - 7);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t4_sb_empty", sbQueue.size(), 0);
    checkOutput("t4_busy_two_out", 32'(busy), 1);
    drainOne();
    step(3);
    checkOutput("t4_busy_one_out", 32'(busy), 1);
    drainOne();
    checkOutput("t4_busy_last_cycle", 32'(busy), 1);
    checkOutput("t4_cnt_three", 32'(frame_cnt), 3);
    step(1);
    checkOutput("t4_busy_fall", 32'(busy), 0);

    // Issue eop and drain eop in the same clock with one frame outstanding.
    startCapture(1'b1, 8'd5);
    sendSamples(LEN);
    step(3);
    fdBase = fdSeen;
    sendSamples(LEN - 1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t5_cnt_one", 32'(frame_cnt), 1);
    checkOutput("t5_fd_pulse", fdSeen - fdBase, 1);
    pulseStop();
    step(10);
    checkOutput("t5_still_outstanding", 32'(busy), 1);
    drainOne();
    checkOutput("t5_cnt_two", 32'(frame_cnt), 2);
    step(1);
    checkOutput("t5_busy_fall", 32'(busy), 0);
    checkOutput("t5_sb_empty", sbQueue.size(), 0);

    // Silent source side after a single frame.
    startCapture(1'b0, 8'd0);
    sendSamples(LEN);
`ifdef FFT_SCHED_WATCHDOG_EN
    wdWait = 0;
    while (busy && wdWait < 70000) begin
      step(1);
      wdWait++;
    end
    checkOutput("t6_wd_in_bound", 32'(wdWait < 70000), 1);
    checkOutput("t6_wd_not_early", 32'(wdWait > 60000), 1);
    checkOutput("t6_err_timeout", 32'(err_timeout), 1);
    checkOutput("t6_busy_idle", 32'(busy), 0);
`else
    step(2000);
    checkOutput("t6_no_timeout", 32'(err_timeout), 0);
    checkOutput("t6_busy_waiting", 32'(busy), 1);
    drainOne();
    step(1);
    checkOutput("t6_busy_idle", 32'(busy), 0);
`endif
    checkOutput("t6_sb_empty", sbQueue.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_frame_sched.md
Name: fft_frame_sched

Overview:
Frame scheduler for the streaming FFT core. It turns a free-running ADC sample strobe into FFT input frames with sink_valid/sink_sop/sink_eop and honours sink_ready. It tracks frames in flight via source_sop/source_eop so the core is never over-committed, and supports single-shot or continuous capture with a programmable inter-frame gap. It replaces the fixed free-running frame counter between the sample path and the FFT core.

Parameters:
FFT_LEN, 1024, points per FFT frame (power of two)
IDX_W, 10, log2(FFT_LEN), width of the sample index
GAP_W, 8, width of the inter-frame gap count
MAX_OUT, 2, maximum frames issued but not yet drained from source side (1..3)

Ports:
sys_clk  in  1  single clock; all logic on rising edge
sys_rst_n  in  1  reset, synchronous and active-low
start  in  1  pulse; begins capture from IDLE, ignored otherwise
stop  in  1  pulse; continuous mode finishes current frame then drains to IDLE
mode_cont  in  1  1 = continuous frames, 0 = single frame; sampled at start
gap_cycles  in  GAP_W  idle clocks between eop and next frame; sampled at start
sample_valid  in  1  one-cycle strobe per new ADC sample
sink_ready  in  1  FFT core can accept input
sink_valid  out  1  registered; sample presented to FFT
sink_sop  out  1  registered; first sample of frame
sink_eop  out  1  registered; last sample of frame
source_valid  in  1  FFT output beat valid
source_sop  in  1  FFT output frame start
source_eop  in  1  FFT output frame end
busy  out  1  high in any state but IDLE
frame_done  out  1  one-cycle pulse per drained output frame
frame_cnt  out  16  output frames drained since start, wraps at 65535->0
err_overrun  out  1  sticky; sample dropped because sink_ready low in LOAD
err_timeout  out  1  sticky watchdog flag (see Optional Feature)

Behaviour:
- Reset (sys_rst_n=0 at an edge): state IDLE; all outputs 0; idx, outstanding, gap counter and latched mode/gap = 0. Reset mid-frame abandons the frame with no eop emitted.
- States: IDLE, LOAD, GAP, WAIT_OUT, DRAIN.
- IDLE: on start, latch mode_cont and gap_cycles, clear err_overrun, err_timeout and frame_cnt. Go to LOAD if outstanding<MAX_OUT, else WAIT_OUT.
- LOAD: on sample_valid&&sink_ready, assert sink_valid next cycle for exactly one clock, with sink_sop=(idx==0) and sink_eop=(idx==FFT_LEN-1); then idx++.
  - Latency sample_valid->sink_valid is 1 clock; the external data register matches this.
  - sample_valid&&!sink_ready: sample dropped, idx unchanged, err_overrun<=1.
  - On the eop beat: idx wraps to 0 and outstanding++.
  - Next state after eop:
    - single mode or stop seen: DRAIN
    - gap_cycles!=0: GAP
    - gap_cycles==0 and outstanding+1<MAX_OUT: LOAD
    - otherwise: WAIT_OUT
- stop: latched as pending in any non-IDLE state. It is acted on only at frame end, or immediately if in GAP or WAIT_OUT (go to DRAIN).
- GAP: counts gap_cycles clocks; samples ignored, with no err_overrun. Then LOAD if outstanding<MAX_OUT, else WAIT_OUT.
- WAIT_OUT: go to LOAD when outstanding<MAX_OUT.
- DRAIN: go to IDLE when outstanding==0; busy falls the cycle after.
- Drain tracking: source_valid&&source_eop gives outstanding-- and a frame_done pulse on the next cycle, and frame_cnt++.
  - Simultaneous issue eop and drain eop: outstanding unchanged, frame_done still pulses.
  - A drain eop when outstanding==0 is ignored (no underflow); frame_done is still pulsed.
- source_sop is not used for counting; it is reserved for the watchdog reset.
- A frame always starts on a fresh sop. idx never carries across frames.

Optional Feature:
Macro FFT_SCHED_WATCHDOG_EN.
- Defined: a 16-bit counter runs while outstanding!=0. It clears on any source_valid&&(source_sop||source_eop). On reaching 65535 it sets err_timeout, zeroes outstanding, clears pending stop and goes to IDLE.
- Undefined: no counter; err_timeout tied 0.

Test Plan:
FFT_LEN=16, sink_ready=1, sample_valid every 4 clocks, mode_cont=0, start -> 16 sink_valid beats, sop on beat 0, eop on beat 15, each 1 clock after its strobe; after one source_eop, frame_done=1 for one clock, frame_cnt=1, busy=0.
mode_cont=1, gap_cycles=5, MAX_OUT=2, source side never drains -> exactly 2 frames issued, state parks in WAIT_OUT; first source_eop -> third frame starts on the next accepted sample with sop.
sink_ready=0 for samples 3-4 of a frame -> those samples dropped, err_overrun=1, eop still on the 16th accepted sample; next start clears err_overrun.
stop pulsed mid-frame at idx=7 in continuous mode -> frame completes to eop, no further sop, busy falls 1 clock after outstanding reaches 0.
Issue eop and source_eop in the same clock with outstanding=1 -> outstanding stays 1, frame_cnt increments by 1.
With FFT_SCHED_WATCHDOG_EN, source side silent for 65535 clocks after a frame -> err_timeout=1, state IDLE, busy=0; without the macro err_timeout stays 0.
